// File: rtl/circular_buffer_reader_if.sv
// Handshake/bus bundle between the circular buffer reader and its controller/consumer.
// master drives control and stride inputs, slave (the reader) drives address and status.
interface circular_buffer_reader_if #(
  parameter int WIDTH     = 3,
  parameter int WIDTH_INC = 2
);
  logic                 stall;
  logic                 clr;
  logic                 ld;
  logic [WIDTH-1:0]     pin;
  logic [WIDTH-1:0]     max_count;
  logic [WIDTH_INC-1:0] inc;
  logic                 wr_adv;
  logic [WIDTH_INC-1:0] wr_inc;
  logic                 rd_ready;
  logic [WIDTH-1:0]     rd_addr;
  logic                 rd_valid;
  logic [WIDTH:0]       occupancy;
  logic                 empty;
  logic                 full;
  logic                 err;

  modport master (
    output stall, clr, ld, pin, max_count, inc, wr_adv, wr_inc, rd_ready,
    input  rd_addr, rd_valid, occupancy, empty, full, err
  );

  modport slave (
    input  stall, clr, ld, pin, max_count, inc, wr_adv, wr_inc, rd_ready,
    output rd_addr, rd_valid, occupancy, empty, full, err
  );
endinterface

// File: rtl/circular_buffer_reader.sv
// Read pointer / occupancy tracker mirroring the wrap-around write counter; 1-cycle write-to-read latency.
// Optional sticky overflow flag built only when CBR_OVERFLOW_ERR_EN is defined (otherwise err is tied 0).
module circular_buffer_reader #(
  parameter int WIDTH     = 3,
  parameter int WIDTH_INC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  circular_buffer_reader_if.slave  bus
);

  logic [WIDTH-1:0]   r_rd_addr;
  logic [WIDTH:0]     r_occupancy;

  logic               w_rd_valid;
  logic               w_pop;
  logic [WIDTH:0]     w_max_ext;
  logic [WIDTH:0]     w_inc_ext;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_wrapped;
  logic [WIDTH+1:0]   w_add;
  logic [WIDTH+1:0]   w_sub;
  logic [WIDTH+1:0]   w_occ_next;
  logic               w_overflow;
  logic [WIDTH:0]     w_occ_sat;

  assign w_max_ext = {1'b0, bus.max_count};
  assign w_inc_ext = (WIDTH+1)'(bus.inc);

  // Pop needs a full stride available, which also rules out occupancy underflow.
  assign w_rd_valid = !bus.stall && (r_occupancy != '0) && (r_occupancy >= w_inc_ext);
  assign w_pop      = w_rd_valid && bus.rd_ready;

  assign w_sum     = {1'b0, r_rd_addr} + w_inc_ext;
  assign w_wrapped = (w_sum >= w_max_ext) ? (w_sum - w_max_ext) : w_sum;

  assign w_add      = bus.wr_adv ? (WIDTH+2)'(bus.wr_inc) : {(WIDTH+2){1'b0}};
  assign w_sub      = w_pop ? (WIDTH+2)'(bus.inc) : {(WIDTH+2){1'b0}};
  assign w_occ_next = {1'b0, r_occupancy} + w_add - w_sub;
  assign w_overflow = w_occ_next > {1'b0, w_max_ext};
  assign w_occ_sat  = w_overflow ? w_max_ext : (WIDTH+1)'(w_occ_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_occupancy <= '0;
    end else if (bus.stall) begin
      r_rd_addr   <= r_rd_addr;
      r_occupancy <= r_occupancy;
    end else if (bus.clr) begin
      r_rd_addr   <= '0;
      r_occupancy <= '0;
    end else if (bus.ld) begin
      r_rd_addr   <= bus.pin;
      r_occupancy <= '0;
    end else begin
      if (w_pop) begin
        r_rd_addr <= WIDTH'(w_wrapped);
      end
      r_occupancy <= w_occ_sat;
    end
  end

`ifdef CBR_OVERFLOW_ERR_EN
  logic r_err;

  // Sticky: only rst or clr release it; ld keeps the history of lost data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (bus.stall) begin
      r_err <= r_err;
    end else if (bus.clr) begin
      r_err <= 1'b0;
    end else if (bus.ld) begin
      r_err <= r_err;
    end else if (w_overflow) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rd_addr   = r_rd_addr;
  assign bus.occupancy = r_occupancy;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.empty     = (r_occupancy == '0);
  assign bus.full      = (r_occupancy == w_max_ext);

endmodule

// File: tb/tb_circular_buffer_reader.sv
// Directed bench for circular_buffer_reader with WIDTH=3, max_count=6, strides of 2.
// Inputs change #1 after a rising edge; outputs are checked in that same settled window.
module tb_circular_buffer_reader;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic exp_err;

  circular_buffer_reader_if #(.WIDTH(3), .WIDTH_INC(2)) bus ();

  circular_buffer_reader #(.WIDTH(3), .WIDTH_INC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall    = 1'b0;
    bus.clr      = 1'b0;
    bus.ld       = 1'b0;
    bus.pin      = 3'd0;
    bus.max_count = 3'd6;
    bus.inc      = 2'd2;
    bus.wr_adv   = 1'b0;
    bus.wr_inc   = 2'd2;
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.stall    = 1'($urandom);
    bus.clr      = 1'($urandom);
    bus.ld       = 1'($urandom);
    bus.pin      = 3'($urandom);
    bus.max_count = 3'($urandom_range(1, 7));
    bus.inc      = 2'($urandom);
    bus.wr_adv   = 1'($urandom);
    bus.wr_inc   = 2'($urandom);
    bus.rd_ready = 1'($urandom);
    step();
    n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.rd_addr); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_fill_drain();
    logic [3:0] exp_occ [3];
    logic [2:0] exp_addr [3];
    exp_occ  = '{4'd2, 4'd4, 4'd6};
    bus.wr_adv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.occupancy !== exp_occ[i]) begin n_fail++; $display("FAIL fill_occ%0d: got %0d want %0d", i, bus.occupancy, exp_occ[i]); end
    end
    bus.wr_adv = 1'b0;
    n_cmp++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", bus.full); end
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL fill_addr: got %0d want 0", bus.rd_addr); end
    exp_addr = '{3'd2, 3'd4, 3'd0};
    exp_occ  = '{4'd4, 4'd2, 4'd0};
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.rd_addr !== exp_addr[i]) begin n_fail++; $display("FAIL drain_addr%0d: got %0d want %0d", i, bus.rd_addr, exp_addr[i]); end
      n_cmp++; if (bus.occupancy !== exp_occ[i]) begin n_fail++; $display("FAIL drain_occ%0d: got %0d want %0d", i, bus.occupancy, exp_occ[i]); end
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL drain_full: got %b want 0", bus.full); end
    idle();
  endtask

  task automatic test_simultaneous();
    bus.ld = 1'b1; bus.pin = 3'd4;
    step();
    bus.ld = 1'b0; bus.wr_adv = 1'b1;
    step();
    n_cmp++; if (bus.occupancy !== 4'd2) begin n_fail++; $display("FAIL simul_pre_occ: got %0d want 2", bus.occupancy); end
    n_cmp++; if (bus.rd_addr !== 3'd4) begin n_fail++; $display("FAIL simul_pre_addr: got %0d want 4", bus.rd_addr); end
    bus.rd_ready = 1'b1;
    step();
    n_cmp++; if (bus.occupancy !== 4'd2) begin n_fail++; $display("FAIL simul_occ: got %0d want 2", bus.occupancy); end
    n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL simul_wrap_addr: got %0d want 0", bus.rd_addr); end
    idle();
  endtask

  task automatic test_stall();
    bus.wr_adv = 1'b1;
    step();
    n_cmp++; if (bus.occupancy !== 4'd4) begin n_fail++; $display("FAIL stall_pre_occ: got %0d want 4", bus.occupancy); end
    bus.stall = 1'b1; bus.wr_adv = 1'b1; bus.rd_ready = 1'b1;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid: got %b want 0", bus.rd_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL stall_addr%0d: got %0d want 0", i, bus.rd_addr); end
      n_cmp++; if (bus.occupancy !== 4'd4) begin n_fail++; $display("FAIL stall_occ%0d: got %0d want 4", i, bus.occupancy); end
    end
    idle();
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_valid: got %b want 1", bus.rd_valid); end
  endtask

  task automatic test_overflow();
`ifdef CBR_OVERFLOW_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.wr_adv = 1'b1;
    step();
    n_cmp++; if (bus.occupancy !== 4'd6) begin n_fail++; $display("FAIL ovf_pre_occ: got %0d want 6", bus.occupancy); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre_err: got %b want 0", bus.err); end
    step();
    n_cmp++; if (bus.occupancy !== 4'd6) begin n_fail++; $display("FAIL ovf_sat_occ: got %0d want 6", bus.occupancy); end
    n_cmp++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL ovf_err: got %b want %b", bus.err, exp_err); end
    bus.wr_adv = 1'b0;
    step();
    n_cmp++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL ovf_err_held: got %b want %b", bus.err, exp_err); end
    bus.ld = 1'b1; bus.pin = 3'd1;
    step();
    n_cmp++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL ovf_err_ld: got %b want %b", bus.err, exp_err); end
    bus.ld = 1'b0; bus.clr = 1'b1;
    step();
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clr: got %b want 0", bus.err); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL ovf_clr_occ: got %0d want 0", bus.occupancy); end
    idle();
  endtask

  task automatic test_load_clear();
    bus.ld = 1'b1; bus.pin = 3'd4; bus.wr_adv = 1'b1;
    step();
    n_cmp++; if (bus.rd_addr !== 3'd4) begin n_fail++; $display("FAIL ld_addr: got %0d want 4", bus.rd_addr); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL ld_occ: got %0d want 0", bus.occupancy); end
    bus.clr = 1'b1; bus.ld = 1'b1; bus.pin = 3'd5;
    step();
    n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL clr_over_ld_addr: got %0d want 0", bus.rd_addr); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL clr_over_ld_occ: got %0d want 0", bus.occupancy); end
    idle();
  endtask

  task automatic test_partial_stride();
    bus.wr_adv = 1'b1; bus.wr_inc = 2'd1; bus.rd_ready = 1'b1;
    step();
    bus.wr_adv = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL partial_valid: got %b want 0", bus.rd_valid); end
    step();
    n_cmp++; if (bus.occupancy !== 4'd1) begin n_fail++; $display("FAIL partial_occ: got %0d want 1", bus.occupancy); end
    n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL partial_addr: got %0d want 0", bus.rd_addr); end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.wr_adv = 1'b1; bus.rd_ready = 1'b1;
    step();
    step();
    n_cmp++; if (bus.rd_addr !== 3'd2) begin n_fail++; $display("FAIL mid_pre_addr: got %0d want 2", bus.rd_addr); end
    bus.stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.rd_addr !== 3'd0) begin n_fail++; $display("FAIL mid_rst_addr: got %0d want 0", bus.rd_addr); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL mid_rst_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %b want 1", bus.empty); end
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    step();
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_stall();
    test_overflow();
    test_load_clear();
    test_partial_stride();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
